// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a bank of multiplexed 7-segment digits.
// Optional leading-zero blanking: define SEG7_LZB_EN.
module seg7_scan_ctrl #(
  parameter int NDIGITS  = 4,
  parameter int PRESCALE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   upd_valid,
  input  logic [4*NDIGITS-1:0]   upd_data,
  output logic                   upd_ready,
  input  logic [2:0]             bright,
  output logic [3:0]             hex,
  output logic                   en,
  output logic [NDIGITS-1:0]     digit_sel,
  output logic                   frame_tick
);

  localparam int DW = $clog2(NDIGITS);
  localparam int PW = $clog2(PRESCALE);
  localparam int TW = PW + 1;

  logic [DW-1:0]          d;
  logic [PW-1:0]          p;
  logic [4*NDIGITS-1:0]   disp;
  logic [4*NDIGITS-1:0]   pend;
  logic                   pend_full;
  logic [2:0]             bl;

  logic                   p_last;
  logic                   d_last;
  logic [TW-1:0]          thr;
  logic                   en_pwm;
  logic                   blank;

`ifdef SEG7_LZB_EN
  logic [NDIGITS-1:0]     hz;
`endif

  always_comb begin
    p_last     = p == PW'(PRESCALE - 1);
    d_last     = d == DW'(NDIGITS - 1);
    frame_tick = p_last & d_last;
    upd_ready  = ~pend_full;
    thr        = TW'({1'b0, bl} + 4'd1)
               * TW'(PRESCALE / 8);
    en_pwm     = {1'b0, p} < thr;
  end

  always_comb begin
    hex       = '0;
    digit_sel = '0;
    blank     = 1'b0;
`ifdef SEG7_LZB_EN
    // hz[i]: nibbles i..top of disp are all zero
    hz = '0;
    hz[NDIGITS-1] = disp[4*NDIGITS-1 -: 4] == 4'd0;
    for (int i = NDIGITS - 2; i >= 0; i--)
      hz[i] = hz[i+1] & (disp[4*i +: 4] == 4'd0);
`endif
    for (int i = 0; i < NDIGITS; i++) begin
      if (d == DW'(i)) begin
        hex          = disp[4*i +: 4];
        digit_sel[i] = 1'b1;
`ifdef SEG7_LZB_EN
        blank        = hz[i] & (i != 0);
`endif
      end
    end
    en = en_pwm & ~blank;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d         <= '0;
      p         <= '0;
      disp      <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      bl        <= 3'd7;
    end else begin
      if (p_last) begin
        p  <= '0;
        bl <= bright;
        d  <= d_last ? '0 : d + 1'b1;
      end else begin
        p  <= p + 1'b1;
      end
      // disp only changes at the frame boundary
      if (frame_tick) begin
        if (pend_full) begin
          disp      <= pend;
          pend_full <= 1'b0;
        end else if (upd_valid) begin
          disp      <= upd_data;
        end
      end else if (upd_valid && !pend_full) begin
        pend      <= upd_data;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl against a
// cycle-count based reference model.
module tb_seg7_scan_ctrl;

  localparam int N  = 4;
  localparam int PS = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           upd_valid = 1'b0;
  logic [4*N-1:0] upd_data = '0;
  logic           upd_ready;
  logic [2:0]     bright = 3'd7;
  logic [3:0]     hex;
  logic           en;
  logic [N-1:0]   digit_sel;
  logic           frame_tick;

  seg7_scan_ctrl #(.NDIGITS(N), .PRESCALE(PS)) dut (
    .clk        (clk),
    .rst        (rst),
    .upd_valid  (upd_valid),
    .upd_data   (upd_data),
    .upd_ready  (upd_ready),
    .bright     (bright),
    .hex        (hex),
    .en         (en),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: position derived from cycles since reset
  int       t      = 0;
  bit       mvalid = 1'b0;
  bit [15:0] mdisp = '0;
  bit [15:0] mpend = '0;
  bit       mfull  = 1'b0;
  int       mbl    = 7;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0h exp=%0h",
               tag, t, got, exp);
    end
  endtask

  function automatic int md();
    return (t / PS) % N;
  endfunction

  function automatic int mp();
    return t % PS;
  endfunction

  function automatic bit mft();
    return md() == N - 1 && mp() == PS - 1;
  endfunction

  function automatic bit men();
    bit on;
    on = mp() < (mbl + 1) * PS / 8;
`ifdef SEG7_LZB_EN
    if (md() >= 1 && (mdisp >> (4 * md())) == 0)
      on = 1'b0;
`endif
    return on;
  endfunction

  task automatic mupd(input bit rs, input bit v,
                      input bit [15:0] dat,
                      input int br);
    if (rs) begin
      t = 0; mdisp = '0; mfull = 1'b0; mbl = 7;
      return;
    end
    if (mft()) begin
      if (mfull) begin
        mdisp = mpend;
        mfull = 1'b0;
      end else if (v) begin
        mdisp = dat;
      end
    end else if (v && !mfull) begin
      mpend = dat;
      mfull = 1'b1;
    end
    if (mp() == PS - 1) mbl = br;
    t++;
  endtask

  task automatic cyc(input bit rs, input bit v,
                     input logic [15:0] dat,
                     input logic [2:0] br);
    @(negedge clk);
    if (mvalid) begin
      check("sel", 32'(digit_sel), 32'(1 << md()));
      check("hex", 32'(hex),
            32'((mdisp >> (4 * md())) & 16'hF));
      check("en", 32'(en), 32'(men()));
      check("tick", 32'(frame_tick), 32'(mft()));
      check("rdy", 32'(upd_ready), 32'(!mfull));
    end
    rst       = rs;
    upd_valid = v;
    upd_data  = dat;
    bright    = br;
    @(posedge clk);
    mupd(rs, v, dat, int'(br));
    mvalid = 1'b1;
    #1;
  endtask

  task automatic idle(input int n, input logic [2:0] br);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, br);
  endtask

  int cnt;
  int lim;
  bit found;

  initial begin
    // reset and idle two frames
    cyc(1, 0, '0, 7);
    cyc(1, 0, '0, 7);
    check("rst_sel", 32'(digit_sel), 1);
    check("rst_en", 32'(en), 1);
    check("rst_rdy", 32'(upd_ready), 1);
    check("rst_hex", 32'(hex), 0);
    cnt = 0;
    for (int i = 0; i < 128; i++) begin
      if (frame_tick)
        check("tick_at", t, (t == 63) ? 63 : 127);
      cnt += int'(frame_tick);
      cyc(0, 0, '0, 7);
    end
    check("tick_cnt", cnt, 2);

    // pended update 0x1234 at cycle 10
    cyc(1, 0, '0, 7);
    idle(10, 7);
    cyc(0, 1, 16'h1234, 7);
    check("pend_rdy", 32'(upd_ready), 0);
    while (t < 63) cyc(0, 0, '0, 7);
    check("pend_tick", 32'(frame_tick), 1);
    check("pend_rdy63", 32'(upd_ready), 0);
    cyc(0, 0, '0, 7);
    check("pend_rdy64", 32'(upd_ready), 1);
    check("hex_d0", 32'(hex), 4);
    idle(16, 7);
    check("hex_d1", 32'(hex), 3);
    idle(16, 7);
    check("hex_d2", 32'(hex), 2);
    idle(16, 7);
    check("hex_d3", 32'(hex), 1);

    // bypass on a tick with nothing pending
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (mft() && !mfull) found = 1'b1;
      else cyc(0, 0, '0, 7);
    end
    check("byp_found", 32'(found), 1);
    check("byp_rdy0", 32'(upd_ready), 1);
    cyc(0, 1, 16'hBEEF, 7);
    check("byp_hex", 32'(hex), 4'hF);
    check("byp_rdy", 32'(upd_ready), 1);

    // PWM: slot 2 keeps bl=1, slot 3 uses 5
    cyc(1, 0, '0, 1);
    cyc(0, 1, 16'hFFFF, 1);
    while (t < 64 + 32) cyc(0, 0, '0, 1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cnt += int'(en);
      cyc(0, 0, '0, (mp() >= 8) ? 3'd5 : 3'd1);
    end
    check("pwm_b1", cnt, 4);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cnt += int'(en);
      cyc(0, 0, '0, 5);
    end
    check("pwm_b5", cnt, 12);

    // leading-zero case 0x0050
    cyc(1, 0, '0, 7);
    cyc(0, 1, 16'h0050, 7);
    while (t < 64) cyc(0, 0, '0, 7);
    check("lz_d0_hex", 32'(hex), 0);
    check("lz_d0_en", 32'(en), 1);
    idle(16, 7);
    check("lz_d1_hex", 32'(hex), 5);
    check("lz_d1_en", 32'(en), 1);
    idle(16, 7);
`ifdef SEG7_LZB_EN
    check("lz_d2_en", 32'(en), 0);
`else
    check("lz_d2_en", 32'(en), 1);
`endif

    // reset at d=2 discards the pending value
    cyc(1, 0, '0, 7);
    idle(5, 7);
    cyc(0, 1, 16'hABCD, 7);
    while (t < 32) cyc(0, 0, '0, 7);
    check("mid_full", 32'(upd_ready), 0);
    cyc(1, 0, '0, 7);
    check("mid_sel", 32'(digit_sel), 1);
    check("mid_hex", 32'(hex), 0);
    check("mid_rdy", 32'(upd_ready), 1);
    cnt = 0;
    for (int i = 0; i < 160; i++) begin
      if (hex != 4'd0) cnt++;
      cyc(0, 0, '0, 7);
    end
    check("mid_nohex", cnt, 0);

    // random traffic
    lim = 4000;
    for (int i = 0; i < lim; i++) begin
      cyc(($urandom % 400) == 0,
          ($urandom % 5) == 0,
          16'($urandom),
          3'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
